column_sequencer: RTL and testbench

//  Consumes quadrature step events (step_en/step_dir) from the encoder decoder and turns wheel travel into
//  LED-column indices for the light painter. Divides steps by STEPS_PER_COL, tracks the column position
//  and runs a painting-pass FSM. Hands each new column to the downstream LED strip driver over valid/ready.

---
 rtl/painter_pkg.sv | 15 +
 rtl/column_sequencer_step_prescaler.sv | 64 ++++++
 rtl/column_sequencer.sv | 168 ++++++++++++++++
 tb/tb_column_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/painter_pkg.sv
// Shared types and default constants for the light-painter column path.
package painter_pkg;

    localparam int DEFAULT_NUM_COLS      = 64;
    localparam int DEFAULT_STEPS_PER_COL = 4;

    // Painting-pass sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PAINT = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/column_sequencer_step_prescaler.sv
// step_prescaler: divides encoder steps into column advance/retreat pulses.
// col_inc/col_dec are combinational pulses in the same cycle as the step that
// crosses a column boundary. With at_floor high, a reverse step that would
// underflow the sub count saturates at zero and produces no pulse.
module step_prescaler
    import painter_pkg::*;
#(
    parameter int STEPS_PER_COL = DEFAULT_STEPS_PER_COL
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic at_floor,
    input  logic step_en,
    input  logic step_dir,
    output logic col_inc,
    output logic col_dec
);

    localparam int SUB_W = $clog2(STEPS_PER_COL + 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(STEPS_PER_COL - 1);

    logic [SUB_W-1:0] sub;
    logic [SUB_W-1:0] sub_n;

    // Next sub count and column boundary pulses
    always_comb begin
        sub_n   = sub;
        col_inc = 1'b0;
        col_dec = 1'b0;
        if (clear) begin
            sub_n = '0;
        end else if (enable && step_en) begin
            if (step_dir) begin
                if (sub == SUB_LAST) begin
                    sub_n   = '0;
                    col_inc = 1'b1;
                end else begin
                    sub_n = sub + 1'b1;
                end
            end else begin
                if (sub != '0) begin
                    sub_n = sub - 1'b1;
                end else if (at_floor) begin
                    sub_n = '0;
                end else begin
                    sub_n   = SUB_LAST;
                    col_dec = 1'b1;
                end
            end
        end
    end

    // Sub count register
    always_ff @(posedge clk) begin
        if (!reset) begin
            sub <= '0;
        end else begin
            sub <= sub_n;
        end
    end

endmodule

// File: rtl/column_sequencer.sv
// column_sequencer: turns encoder travel into LED column requests.
// Runs the IDLE/ARMED/PAINT/DONE pass FSM, tracks the column position and
// issues columns over valid/ready, coalescing columns passed while stalled.
// Optional macro COLUMN_WRAP_EN: travel past either end wraps the column
// position and the pass never ends by travel.
module column_sequencer
    import painter_pkg::*;
#(
    parameter int NUM_COLS      = DEFAULT_NUM_COLS,
    parameter int STEPS_PER_COL = DEFAULT_STEPS_PER_COL,
    parameter int COL_W         = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_en,
    input  logic             step_dir,
    input  logic             arm,
    input  logic             col_ready,
    output logic             col_valid,
    output logic [COL_W-1:0] col_idx,
    output logic             painting,
    output logic             overflow
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    seq_state_t       state;
    seq_state_t       state_n;
    logic [COL_W-1:0] pos;
    logic [COL_W-1:0] pos_n;
    logic             change;
    logic             col_inc;
    logic             col_dec;
    logic             at_floor;
    logic             skip;
    logic             xfer;
    logic             reissue;

`ifdef COLUMN_WRAP_EN
    assign at_floor = 1'b0;
`else
    assign at_floor = (pos == '0);
`endif

    step_prescaler #(
        .STEPS_PER_COL(STEPS_PER_COL)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .clear   (arm),
        .enable  ((state == PAINT) && !arm),
        .at_floor(at_floor),
        .step_en (step_en),
        .step_dir(step_dir),
        .col_inc (col_inc),
        .col_dec (col_dec)
    );

    assign painting = (state == PAINT);
    assign xfer     = col_valid && col_ready;
    // After a transfer, catch up to a position that moved on while stalled;
    // suppressed in ARMED so a restart does not re-send a stale column.
    assign reissue  = !arm && ((state == PAINT) || (state == DONE)) && (pos != col_idx);

    // Pass FSM and position update; change flags a new column to announce
    always_comb begin
        state_n = state;
        pos_n   = pos;
        change  = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_n = ARMED;
                    pos_n   = '0;
                end
            end
            ARMED: begin
                if (arm) begin
                    pos_n = '0;
                end else if (step_en && step_dir) begin
                    state_n = PAINT;
                    pos_n   = '0;
                    change  = 1'b1;
                end
            end
            PAINT: begin
                if (arm) begin
                    state_n = ARMED;
                    pos_n   = '0;
                end else if (col_inc) begin
                    if (pos == LAST_COL) begin
`ifdef COLUMN_WRAP_EN
                        pos_n  = '0;
                        change = 1'b1;
`else
                        state_n = DONE;
`endif
                    end else begin
                        pos_n  = pos + 1'b1;
                        change = 1'b1;
                    end
                end else if (col_dec) begin
                    if (pos == '0) begin
`ifdef COLUMN_WRAP_EN
                        pos_n  = LAST_COL;
                        change = 1'b1;
`else
                        pos_n  = '0;
`endif
                    end else begin
                        pos_n  = pos - 1'b1;
                        change = 1'b1;
                    end
                end
            end
            DONE: begin
                if (arm) begin
                    state_n = ARMED;
                    pos_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                pos_n   = '0;
            end
        endcase
    end

    // State, position and request/coalesce registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            pos       <= '0;
            col_valid <= 1'b0;
            col_idx   <= '0;
            skip      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_n;
            pos   <= pos_n;
            if (arm) begin
                overflow <= 1'b0;
                skip     <= 1'b0;
            end
            if (change) begin
                if (!col_valid || xfer) begin
                    col_valid <= 1'b1;
                    col_idx   <= pos_n;
                    skip      <= 1'b0;
                end else begin
                    skip <= 1'b1;
                    if (skip) begin
                        overflow <= 1'b1;
                    end
                end
            end else if (xfer) begin
                skip <= 1'b0;
                if (reissue) begin
                    col_valid <= 1'b1;
                    col_idx   <= pos;
                end else begin
                    col_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_column_sequencer.sv
// Testbench for column_sequencer (NUM_COLS=8, STEPS_PER_COL=4).
// Reference model tracks total travel in steps within the pass and derives
// the column as travel / STEPS_PER_COL. Honours COLUMN_WRAP_EN.
module tb_column_sequencer;

    localparam int N  = 8;
    localparam int S  = 4;
    localparam int CW = 3;
    localparam int NS = N * S;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_PAINT = 2;
    localparam int M_DONE  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          step_en = 1'b0;
    logic          step_dir = 1'b0;
    logic          arm = 1'b0;
    logic          col_ready = 1'b1;
    logic          col_valid;
    logic [CW-1:0] col_idx;
    logic          painting;
    logic          overflow;

    int checks = 0;
    int failures = 0;

    int m_mode = M_IDLE;
    int m_t = 0;
    bit m_valid = 1'b0;
    int m_idx = 0;
    int m_sc = 0;
    bit m_ovf = 1'b0;

    always #5 clk = ~clk;

    column_sequencer #(
        .NUM_COLS(N),
        .STEPS_PER_COL(S),
        .COL_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .step_en(step_en),
        .step_dir(step_dir),
        .arm(arm),
        .col_ready(col_ready),
        .col_valid(col_valid),
        .col_idx(col_idx),
        .painting(painting),
        .overflow(overflow)
    );

    task automatic model_clock();
        bit xfer;
        bit changed;
        int newcol;
        int oldc;
        int prev;
        if (!reset) begin
            m_mode = M_IDLE; m_t = 0; m_valid = 0; m_idx = 0; m_sc = 0; m_ovf = 0;
            return;
        end
        xfer = m_valid && col_ready;
        changed = 0;
        newcol = 0;
        prev = m_mode;
        if (arm) begin
            m_mode = M_ARMED; m_t = 0; m_ovf = 0; m_sc = 0;
        end else if (step_en) begin
            if (m_mode == M_ARMED && step_dir) begin
                m_mode = M_PAINT; m_t = 0; changed = 1; newcol = 0;
            end else if (m_mode == M_PAINT) begin
                oldc = m_t / S;
                m_t = m_t + (step_dir ? 1 : -1);
`ifdef COLUMN_WRAP_EN
                m_t = (m_t + NS) % NS;
`else
                if (m_t < 0) m_t = 0;
                if (m_t >= NS) begin
                    m_t = NS - 1;
                    m_mode = M_DONE;
                end
`endif
                newcol = m_t / S;
                changed = (m_mode == M_PAINT) && (newcol != oldc);
            end
        end
        if (changed) begin
            if (!m_valid || xfer) begin
                m_valid = 1; m_idx = newcol; m_sc = 0;
            end else begin
                m_sc++;
                if (m_sc >= 2) m_ovf = 1;
            end
        end else if (xfer) begin
            if (!arm && (prev == M_PAINT || prev == M_DONE) && (m_t / S) != m_idx) begin
                m_valid = 1; m_idx = m_t / S;
            end else begin
                m_valid = 0;
            end
            m_sc = 0;
        end
    endtask

    task automatic tick(input logic a, input logic e, input logic d, input logic r);
        arm = a; step_en = e; step_dir = d; col_ready = r;
        @(posedge clk);
        model_clock();
        #1;
        arm = 1'b0; step_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        checks++; if (col_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", col_valid); end
        checks++; if (col_idx !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d want=0", col_idx); end
        checks++; if (painting !== 1'b0) begin failures++; $display("FAIL reset_painting got=%0b want=0", painting); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
        reset = 1'b1;
    endtask

    task automatic test_first_column();
        tick(1, 0, 0, 1);
        tick(0, 1, 1, 1);
        checks++; if (col_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%0b want=1", col_valid); end
        checks++; if (col_idx !== 3'd0) begin failures++; $display("FAIL first_idx got=%0d want=0", col_idx); end
        checks++; if (painting !== 1'b1) begin failures++; $display("FAIL first_painting got=%0b want=1", painting); end
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 1, 1);
            checks++; if (col_valid !== 1'b0) begin failures++; $display("FAIL substep_valid step=%0d got=%0b want=0", i, col_valid); end
        end
        tick(0, 1, 1, 1);
        checks++; if (col_valid !== 1'b1) begin failures++; $display("FAIL col1_valid got=%0b want=1", col_valid); end
        checks++; if (col_idx !== 3'd1) begin failures++; $display("FAIL col1_idx got=%0d want=1", col_idx); end
        tick(0, 0, 0, 1);
    endtask

    task automatic test_reverse();
        for (int i = 0; i < 8; i++) tick(0, 1, 1, 1);
        tick(0, 0, 0, 1);
        tick(0, 1, 0, 1);
        checks++; if (col_valid !== 1'b1) begin failures++; $display("FAIL rev_valid got=%0b want=1", col_valid); end
        checks++; if (col_idx !== 3'd2) begin failures++; $display("FAIL rev_idx got=%0d want=2", col_idx); end
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 1);
            checks++; if (col_valid !== 1'b0) begin failures++; $display("FAIL rev_sub_valid step=%0d got=%0b want=0", i, col_valid); end
        end
    endtask

    task automatic test_coalesce();
        reset = 1'b0;
        tick(0, 0, 0, 1);
        reset = 1'b1;
        tick(1, 0, 0, 1);
        tick(0, 1, 1, 1);
        tick(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) tick(0, 1, 1, 0);
        for (int i = 0; i < 8; i++) tick(0, 1, 1, 0);
        checks++; if (col_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%0b want=1", col_valid); end
        checks++; if (col_idx !== 3'd1) begin failures++; $display("FAIL stall_idx got=%0d want=1", col_idx); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL stall_overflow got=%0b want=1", overflow); end
        tick(0, 0, 0, 1);
        checks++; if (col_valid !== 1'b1) begin failures++; $display("FAIL catchup_valid got=%0b want=1", col_valid); end
        checks++; if (col_idx !== 3'd3) begin failures++; $display("FAIL catchup_idx got=%0d want=3", col_idx); end
        tick(0, 0, 0, 1);
        checks++; if (col_valid !== 1'b0) begin failures++; $display("FAIL catchup_drain got=%0b want=0", col_valid); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%0b want=1", overflow); end
    endtask

    task automatic test_end();
        for (int i = 0; i < 16; i++) tick(0, 1, 1, 1);
        checks++; if (col_idx !== 3'd7) begin failures++; $display("FAIL last_idx got=%0d want=7", col_idx); end
        for (int i = 0; i < 4; i++) tick(0, 1, 1, 1);
`ifdef COLUMN_WRAP_EN
        checks++; if (painting !== 1'b1) begin failures++; $display("FAIL wrap_painting got=%0b want=1", painting); end
        checks++; if (col_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid got=%0b want=1", col_valid); end
        checks++; if (col_idx !== 3'd0) begin failures++; $display("FAIL wrap_idx got=%0d want=0", col_idx); end
`else
        checks++; if (painting !== 1'b0) begin failures++; $display("FAIL done_painting got=%0b want=0", painting); end
        checks++; if (col_valid !== 1'b0) begin failures++; $display("FAIL done_valid got=%0b want=0", col_valid); end
        checks++; if (col_idx !== 3'd7) begin failures++; $display("FAIL done_idx got=%0d want=7", col_idx); end
        tick(0, 1, 1, 1);
        checks++; if (col_valid !== 1'b0) begin failures++; $display("FAIL done_step_valid got=%0b want=0", col_valid); end
`endif
        tick(1, 0, 0, 1);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL arm_clears_overflow got=%0b want=0", overflow); end
        checks++; if (painting !== 1'b0) begin failures++; $display("FAIL armed_painting got=%0b want=0", painting); end
    endtask

    task automatic test_arm_step_same_cycle();
        reset = 1'b0;
        tick(0, 0, 0, 1);
        reset = 1'b1;
        tick(1, 1, 1, 1);
        checks++; if (col_valid !== 1'b0) begin failures++; $display("FAIL armstep_valid got=%0b want=0", col_valid); end
        checks++; if (painting !== 1'b0) begin failures++; $display("FAIL armstep_painting got=%0b want=0", painting); end
        tick(0, 1, 1, 1);
        checks++; if (painting !== 1'b1) begin failures++; $display("FAIL armed_entry_painting got=%0b want=1", painting); end
        checks++; if (col_valid !== 1'b1) begin failures++; $display("FAIL armed_entry_valid got=%0b want=1", col_valid); end
    endtask

    task automatic test_reset_midpass();
        reset = 1'b0;
        tick(0, 0, 0, 0);
        checks++; if ({col_valid, col_idx, painting, overflow} !== '0) begin
            failures++;
            $display("FAIL midpass_reset got valid=%0b idx=%0d painting=%0b overflow=%0b want all 0", col_valid, col_idx, painting, overflow);
        end
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic r;
        logic a;
        logic e;
        logic d;
        int ready_pct;
        reset = 1'b0;
        tick(0, 0, 0, 1);
        reset = 1'b1;
        tick(1, 0, 0, 1);
        ready_pct = 70;
        for (int c = 0; c < 4000; c++) begin
            if (c % 32 == 0) ready_pct = ($urandom_range(0, 1) == 0) ? 10 : 90;
            a = ($urandom_range(0, 63) == 0);
            e = ($urandom_range(0, 1) == 1);
            d = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 99) < ready_pct);
            tick(a, e, d, r);
            checks++; if (col_valid !== m_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", c, col_valid, m_valid); end
            checks++; if (col_idx !== CW'(m_idx)) begin failures++; $display("FAIL rnd_idx cyc=%0d got=%0d want=%0d", c, col_idx, m_idx); end
            checks++; if (painting !== (m_mode == M_PAINT)) begin failures++; $display("FAIL rnd_painting cyc=%0d got=%0b want=%0b", c, painting, m_mode == M_PAINT); end
            checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_overflow cyc=%0d got=%0b want=%0b", c, overflow, m_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_first_column();
        test_reverse();
        test_coalesce();
        test_end();
        test_arm_step_same_cycle();
        test_reset_midpass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
